// File: rtl/ioports_pkg.sv
// Shared definitions for the serial port-access command responder:
// command opcodes, FSM state encoding and port geometry.
package ioports_pkg;

   localparam int unsigned NUM_PORTS = 16;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BUS_W     = NUM_PORTS * WORD_W;

   localparam logic [3:0] CMD_WRITE = 4'b0010;
   localparam logic [3:0] CMD_READ  = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_RD_SNAP,
      ST_RD_SEND,
      ST_RD_HOLD
   } state_t;

   // Extract 32-bit word idx from a packed 16x32 port bus.
   function automatic logic [WORD_W-1:0] port_word(input logic [BUS_W-1:0] vec,
                                                   input logic [3:0]       idx);
      return vec[{idx, 5'd0} +: WORD_W];
   endfunction

endpackage

// File: rtl/ioports_ctrl_if.sv
// UART byte stream and user port bundle of the command responder.
// slave: the responder itself; master: the UART/datapath side driving it.
interface ioports_ctrl_if;
   import ioports_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_ready;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_en;
   logic              tx_ready;
   logic [BUS_W-1:0]  out_ports;
   logic [NUM_PORTS-1:0] wr_strobe;
   logic [BUS_W-1:0]  in_ports;
   logic              busy;

   modport slave (
      input  rx_data, rx_ready, tx_ready, in_ports,
      output tx_data, tx_en, out_ports, wr_strobe, busy
   );

   modport master (
      output rx_data, rx_ready, tx_ready, in_ports,
      input  tx_data, tx_en, out_ports, wr_strobe, busy
   );

endinterface

// File: rtl/ioports_ctrl.sv
// Byte-level command responder: decodes WRITE/READ commands arriving from
// the UART, drives 16 32-bit output ports and returns coherent snapshots of
// 16 32-bit input ports as four MSB-first bytes.
module ioports_ctrl
   import ioports_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [NUM_PORTS-1:0] AUTOCLR_MASK = 16'h8000
) (
   input logic          clock,
   input logic          reset,
   ioports_ctrl_if.slave bus
);

   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t              state;
   logic [3:0]          port_sel;
   logic [1:0]          byte_cnt;
   logic [WORD_W-1:0]   shift_reg;
   logic [TMR_W-1:0]    timer;
   logic [BUS_W-1:0]    out_reg;
   logic [NUM_PORTS-1:0] strobe;

   // Command FSM, byte assembly/serialisation, inter-byte timer and port registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         port_sel  <= '0;
         byte_cnt  <= '0;
         shift_reg <= '0;
         timer     <= '0;
         out_reg   <= '0;
         strobe    <= '0;
      end else begin
         strobe <= '0;

         // Auto-clear ports drop to zero every clock; a write in this same
         // clock is assigned later below and therefore wins for one cycle.
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (AUTOCLR_MASK[4'(k)]) begin
               out_reg[{4'(k), 5'd0} +: WORD_W] <= '0;
            end
         end

         case (state)
            ST_IDLE: begin
               if (bus.rx_ready) begin
                  case (bus.rx_data[7:4])
                     CMD_WRITE: begin
                        port_sel <= bus.rx_data[3:0];
                        byte_cnt <= '0;
                        timer    <= '0;
                        state    <= ST_WR_DATA;
                     end
                     CMD_READ: begin
                        port_sel <= bus.rx_data[3:0];
                        state    <= ST_RD_SNAP;
                     end
                     default: ;
                  endcase
               end
            end

            ST_WR_DATA: begin
               if (bus.rx_ready) begin
                  shift_reg <= {shift_reg[WORD_W-BYTE_W-1:0], bus.rx_data};
                  timer     <= '0;
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     out_reg[{port_sel, 5'd0} +: WORD_W] <=
                        {shift_reg[WORD_W-BYTE_W-1:0], bus.rx_data};
                     strobe[port_sel] <= 1'b1;
                     state            <= ST_IDLE;
                  end
               end else if (timer == TMR_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            ST_RD_SNAP: begin
               shift_reg <= port_word(bus.in_ports, port_sel);
               byte_cnt  <= '0;
               state     <= ST_RD_SEND;
            end

            ST_RD_SEND: begin
               if (bus.tx_ready) begin
                  state <= ST_RD_HOLD;
               end
            end

            ST_RD_HOLD: begin
               shift_reg <= {shift_reg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               byte_cnt  <= byte_cnt + 2'd1;
               state     <= (byte_cnt == 2'd3) ? ST_IDLE : ST_RD_SEND;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // tx_en is decoded from the registered state together with tx_ready so the
   // UART is loaded in the very cycle readiness is seen; RD_HOLD then masks
   // the stale tx_ready while the UART drops it.
   assign bus.tx_en     = (state == ST_RD_SEND) && bus.tx_ready;
   assign bus.tx_data   = (state == ST_RD_SEND) ? shift_reg[WORD_W-1 -: BYTE_W] : '0;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.out_ports = out_reg;
   assign bus.wr_strobe = strobe;

endmodule

// File: tb/tb_ioports_ctrl.sv
// Self-checking bench for ioports_ctrl: a behavioural UART peer and a
// port-array model check writes, auto-clear, snapshot reads, dropped bytes,
// inter-byte timeout and reset behaviour under randomized stimulus.
module tb_ioports_ctrl;
   import ioports_pkg::*;

   localparam int unsigned TMO = 64;
   localparam logic [15:0] ACLR = 16'h8000;

   logic clock = 1'b0;
   logic reset;

   ioports_ctrl_if bus();

   ioports_ctrl #(.TIMEOUT_CYCLES(TMO), .AUTOCLR_MASK(ACLR)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // UART peer / protocol monitor state
   int         cyc = 0;
   int         uart_left = 0;
   int         tx_delay = 1;
   int         proto_bad = 0;
   int         strobe_events = 0;
   logic       prev_tx_en = 1'b0;
   logic [7:0] tx_bytes[$];
   int         tx_cycles[$];

   // Reference model
   logic [31:0] model_ports [16];
   logic [15:0] aclr_mask = ACLR;
   int          last_rx_cyc = 0;

   assign bus.tx_ready = (uart_left == 0);

   // UART transmitter model: accepts a byte on tx_en, stays busy for
   // tx_delay+1 clocks, and records protocol violations.
   always @(posedge clock) begin
      cyc        <= cyc + 1;
      prev_tx_en <= bus.tx_en;
      strobe_events <= strobe_events + $countones(bus.wr_strobe);
      if (bus.tx_en === 1'b1) begin
         tx_bytes.push_back(bus.tx_data);
         tx_cycles.push_back(cyc);
         proto_bad <= proto_bad + ((uart_left != 0) ? 1 : 0) + (prev_tx_en ? 1 : 0);
         uart_left <= tx_delay + 1;
      end else if (uart_left != 0) begin
         uart_left <= uart_left - 1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   function automatic logic [511:0] exp_ports();
      logic [511:0] v;
      v = '0;
      for (int unsigned k = 0; k < 16; k++) v[{4'(k), 5'd0} +: 32] = model_ports[k];
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      last_rx_cyc  = cyc;
      @(negedge clock);
      bus.rx_ready = 1'b0;
   endtask

   task automatic randomize_inputs();
      for (int unsigned k = 0; k < 16; k++) bus.in_ports[{4'(k), 5'd0} +: 32] = $urandom();
   endtask

   // gap < 0 selects random 0..3 idle clocks between bytes
   task automatic do_write(input logic [3:0] p, input logic [31:0] d, input int gap);
      int g;
      logic [511:0] e;
      logic [7:0] b;
      send_byte({CMD_WRITE, p});
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL write_busy port=%0d got=%b want=1", p, bus.busy);
      end
      for (int i = 0; i < 4; i++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         idle(g);
         b = d[31 - 8*i -: 8];
         send_byte(b);
      end
      model_ports[p] = d;
      e = exp_ports();
      checks++;
      if (bus.out_ports !== e) begin
         errors++;
         $display("FAIL write_ports port=%0d got=%h want=%h", p, bus.out_ports, e);
      end
      checks++;
      if (bus.wr_strobe !== (16'd1 << p)) begin
         errors++;
         $display("FAIL write_strobe port=%0d got=%h want=%h", p, bus.wr_strobe, 16'd1 << p);
      end
      @(negedge clock);
      if (aclr_mask[p]) model_ports[p] = '0;
      e = exp_ports();
      checks++;
      if (bus.out_ports !== e) begin
         errors++;
         $display("FAIL write_after port=%0d got=%h want=%h", p, bus.out_ports, e);
      end
      checks++;
      if (bus.wr_strobe !== 16'h0000 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL write_settle port=%0d strobe=%h busy=%b want 0/0", p, bus.wr_strobe, bus.busy);
      end
   endtask

   // mode 0: inputs static, 1: port word zeroed after snapshot, 2: all inputs randomized every clock
   task automatic do_read(input logic [3:0] p, input logic [31:0] v, input int mode);
      int start;
      int budget;
      logic [7:0] e;
      bus.in_ports[{p, 5'd0} +: 32] = v;
      start = tx_bytes.size();
      send_byte({CMD_READ, p});
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL read_busy port=%0d got=%b want=1", p, bus.busy);
      end
      @(posedge clock);
      #1;
      if (mode == 1) bus.in_ports[{p, 5'd0} +: 32] = '0;
      if (mode == 2) randomize_inputs();
      budget = 0;
      while (tx_bytes.size() < start + 4 && budget < 300) begin
         @(negedge clock);
         if (mode == 2) randomize_inputs();
         budget++;
      end
      checks++;
      if (tx_bytes.size() < start + 4) begin
         errors++;
         $display("FAIL read_timeout port=%0d got=%0d bytes want=4", p, tx_bytes.size() - start);
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = v[31 - 8*i -: 8];
            checks++;
            if (tx_bytes[start + i] !== e) begin
               errors++;
               $display("FAIL read_byte%0d port=%0d got=%h want=%h", i, p, tx_bytes[start + i], e);
            end
         end
         checks++;
         if (tx_cycles[start] - last_rx_cyc < 2) begin
            errors++;
            $display("FAIL read_latency port=%0d got=%0d want>=2", p, tx_cycles[start] - last_rx_cyc);
         end
      end
      budget = 0;
      while (bus.busy !== 1'b0 && budget < 50) begin
         @(negedge clock);
         budget++;
      end
      idle(3);
      checks++;
      if (bus.busy !== 1'b0 || tx_bytes.size() != start + 4) begin
         errors++;
         $display("FAIL read_end port=%0d busy=%b bytes=%0d want 0/4", p, bus.busy, tx_bytes.size() - start);
      end
   endtask

   task automatic check_reset_state(input string tag);
      checks++;
      if (bus.out_ports !== '0 || bus.wr_strobe !== '0 || bus.tx_en !== 1'b0 ||
          bus.tx_data !== 8'h00 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s ports_nz=%b strobe=%h tx_en=%b tx_data=%h busy=%b want all 0",
                  tag, |bus.out_ports, bus.wr_strobe, bus.tx_en, bus.tx_data, bus.busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.rx_ready = 1'b0;
      bus.rx_data  = '0;
      bus.in_ports = '0;
      for (int i = 0; i < 16; i++) model_ports[i] = '0;
      idle(3);
      check_reset_state("reset_values");
      reset = 1'b0;
      idle(2);
      check_reset_state("post_reset_idle");
   endtask

   task automatic test_write();
      do_write(4'd3, 32'hDEADBEEF, 0);
      do_write(4'd7, 32'h12345678, -1);
   endtask

   task automatic test_autoclear();
      do_write(4'd15, 32'h00000001, 0);
      do_write(4'd15, 32'hA5A5A5A5, -1);
   endtask

   task automatic test_read();
      tx_delay = 0;
      do_read(4'd0, 32'h0000FFFF, 1);
      tx_delay = 3;
      do_read(4'd0, 32'h0000FFFF, 1);
      tx_delay = 7;
      do_read(4'd9, 32'hC0FFEE42, 2);
   endtask

   task automatic test_invalid();
      int start;
      start = tx_bytes.size();
      send_byte(8'h45);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL invalid_busy got=%b want=0", bus.busy);
      end
      idle(6);
      checks++;
      if (tx_bytes.size() != start) begin
         errors++;
         $display("FAIL invalid_reply got=%0d bytes want=0", tx_bytes.size() - start);
      end
      tx_delay = 1;
      do_read(4'd0, 32'h89ABCDEF, 0);
   endtask

   task automatic test_timeout();
      int sev;
      logic [511:0] e;
      send_byte(8'h21);
      send_byte(8'hAB);
      sev = strobe_events;
      idle(TMO + 1);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle got busy=%b want=0", bus.busy);
      end
      e = exp_ports();
      checks++;
      if (strobe_events != sev || bus.out_ports !== e) begin
         errors++;
         $display("FAIL timeout_discard strobes=%0d want=0 ports_ok=%b", strobe_events - sev, bus.out_ports === e);
      end
      do_write(4'd1, 32'h01020304, -1);
      // gap of TMO-2 idle clocks stays just inside the limit
      do_write(4'd4, 32'h0BADF00D, int'(TMO) - 3);
   endtask

   task automatic test_reset_mid();
      int start;
      int budget;
      // reset in the middle of a write
      send_byte(8'h22);
      send_byte(8'h11);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) model_ports[i] = '0;
      check_reset_state("reset_mid_write");
      do_write(4'd2, 32'h00000007, 0);
      // reset in the middle of a reply
      tx_delay = 10;
      bus.in_ports[{4'd5, 5'd0} +: 32] = 32'h11223344;
      start = tx_bytes.size();
      send_byte({CMD_READ, 4'd5});
      budget = 0;
      while (tx_bytes.size() == start && budget < 50) begin
         @(negedge clock);
         budget++;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) model_ports[i] = '0;
      check_reset_state("reset_mid_read");
      idle(60);
      checks++;
      if (tx_bytes.size() != start + 1) begin
         errors++;
         $display("FAIL reset_abandon got=%0d bytes want=1", tx_bytes.size() - start);
      end
   endtask

   task automatic test_random();
      int op;
      logic [3:0] p;
      logic [3:0] nib;
      for (int n = 0; n < 30; n++) begin
         op = int'($urandom_range(0, 2));
         p  = 4'($urandom_range(0, 15));
         tx_delay = int'($urandom_range(0, 4));
         if (op == 0) begin
            do_write(p, $urandom(), -1);
         end else if (op == 1) begin
            randomize_inputs();
            do_read(p, $urandom(), 2);
         end else begin
            nib = 4'($urandom_range(0, 15));
            if (nib == CMD_WRITE || nib == CMD_READ) nib = 4'hF;
            send_byte({nib, p});
            checks++;
            if (bus.busy !== 1'b0) begin
               errors++;
               $display("FAIL random_invalid op=%h got busy=%b want=0", nib, bus.busy);
            end
         end
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (proto_bad != 0) begin
         errors++;
         $display("FAIL tx_protocol got=%0d violations want=0", proto_bad);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_autoclear();
      test_read();
      test_invalid();
      test_timeout();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
